// File: rtl/i2c_master_byte_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_master_byte_ctrl                                         |
// | Description : Byte-level sequencer of the I2C master. Breaks one byte      |
// |               command (optional START, WRITE or READ of 8 bits, ACK phase,  |
// |               optional STOP) into single-bit commands for the bit          |
// |               controller. Shifts data MSB-first and reports completion,    |
// |               the received ACK and arbitration loss upstream.              |
// | Option      : define I2C_BYTE_CTRL_TIMEOUT_EN to add a watchdog that       |
// |               aborts a stalled transfer after TIMEOUT_CYCLES clk cycles.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Ports:
//   clk, rstn        core clock, synchronous active-low reset
//   ena              core enable; low forces IDLE
//   start/stop/read/write  command bits, held until cmd_ack
//   ack_in           ACK bit sent by the master after a READ (0 = ACK)
//   din / dout       byte to transmit / received byte (dout is the shift reg)
//   cmd_ack          one-cycle completion pulse
//   ack_out          ACK received from the slave after a WRITE
//   i2c_al           arbitration lost (combinational copy of bit_al)
//   timeout          one-cycle watchdog abort pulse (0 without the option)
//   fsm_busy         high while not IDLE
//   bit_cmd/bit_ack/bit_al/bit_din/bit_dout  bit-controller handshake
module i2c_master_byte_ctrl #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ena,
  input  logic       start,
  input  logic       stop,
  input  logic       read,
  input  logic       write,
  input  logic       ack_in,
  input  logic [7:0] din,
  output logic       cmd_ack,
  output logic       ack_out,
  output logic [7:0] dout,
  output logic       i2c_al,
  output logic       timeout,
  output logic       fsm_busy,
  output logic [3:0] bit_cmd,
  input  logic       bit_ack,
  input  logic       bit_al,
  output logic       bit_din,
  input  logic       bit_dout
);

  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_ACK   = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] bit_cmd_q, bit_cmd_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       cmd_ack_q, cmd_ack_d;
  logic       ack_out_q, ack_out_d;
  logic       timeout_q, timeout_d;
  logic       fsm_busy_q, fsm_busy_d;

  logic       go;
  logic       wd_hit;

  // Masking go with the registered cmd_ack stops held command bits from
  // relaunching the byte in the completion cycle.
  assign go = (read | write | stop) & ~cmd_ack_q;

`ifdef I2C_BYTE_CTRL_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;

  // Watchdog: cleared in IDLE and on every bit_ack. It fires on the edge
  // that would make the count reach TIMEOUT_CYCLES, so the abort lands
  // exactly TIMEOUT_CYCLES edges after the command leaves IDLE.
  always_comb begin
    wd_d   = wd_q;
    wd_hit = 1'b0;
    if ((state_q == ST_IDLE) || bit_ack) begin
      wd_d = '0;
    end else if ((32'(wd_q) + 32'd1) >= 32'(TIMEOUT_CYCLES)) begin
      wd_d   = '0;
      wd_hit = 1'b1;
    end else begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cmd_d = bit_cmd_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    cmd_ack_d = 1'b0;
    ack_out_d = ack_out_q;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          sr_d  = din;
          cnt_d = 3'd7;
          if (start) begin
            state_d   = ST_START;
            bit_cmd_d = CMD_START;
          end else if (read) begin
            state_d   = ST_READ;
            bit_cmd_d = CMD_READ;
          end else if (write) begin
            state_d   = ST_WRITE;
            bit_cmd_d = CMD_WRITE;
          end else begin
            state_d   = ST_STOP;
            bit_cmd_d = CMD_STOP;
          end
        end
      end

      ST_START: begin
        if (bit_ack) begin
          if (read) begin
            state_d   = ST_READ;
            bit_cmd_d = CMD_READ;
          end else begin
            state_d   = ST_WRITE;
            bit_cmd_d = CMD_WRITE;
          end
        end
      end

      ST_WRITE, ST_READ: begin
        if (bit_ack) begin
          sr_d  = {sr_q[6:0], bit_dout};
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
            state_d = ST_ACK;
            // The ACK bit travels in the opposite direction to the data.
            bit_cmd_d = (state_q == ST_WRITE) ? CMD_READ : CMD_WRITE;
          end
        end
      end

      ST_ACK: begin
        if (bit_ack) begin
          ack_out_d = bit_dout;
          if (stop) begin
            state_d   = ST_STOP;
            bit_cmd_d = CMD_STOP;
          end else begin
            state_d   = ST_IDLE;
            bit_cmd_d = CMD_NOP;
            cmd_ack_d = 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (bit_ack) begin
          state_d   = ST_IDLE;
          bit_cmd_d = CMD_NOP;
          cmd_ack_d = 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        bit_cmd_d = CMD_NOP;
      end
    endcase

    // Abort overrides any advance, including a bit_ack in the same cycle;
    // sr and ack_out are left untouched so upstream can inspect them.
    if (!ena || bit_al || wd_hit) begin
      state_d   = ST_IDLE;
      bit_cmd_d = CMD_NOP;
      sr_d      = sr_q;
      cnt_d     = 3'd0;
      cmd_ack_d = 1'b0;
      ack_out_d = ack_out_q;
    end

    timeout_d  = wd_hit & ena & ~bit_al;
    fsm_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      bit_cmd_q  <= CMD_NOP;
      sr_q       <= 8'h00;
      cnt_q      <= 3'd0;
      cmd_ack_q  <= 1'b0;
      ack_out_q  <= 1'b0;
      timeout_q  <= 1'b0;
      fsm_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cmd_q  <= bit_cmd_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      cmd_ack_q  <= cmd_ack_d;
      ack_out_q  <= ack_out_d;
      timeout_q  <= timeout_d;
      fsm_busy_q <= fsm_busy_d;
    end
  end

  // During the ACK phase of a READ byte (bit_cmd WRITE) the master drives
  // its own ACK/NACK; otherwise the MSB of the shift register goes out.
  assign bit_din  = ((state_q == ST_ACK) && (bit_cmd_q == CMD_WRITE)) ? ack_in : sr_q[7];
  assign bit_cmd  = bit_cmd_q;
  assign dout     = sr_q;
  assign cmd_ack  = cmd_ack_q;
  assign ack_out  = ack_out_q;
  assign timeout  = timeout_q;
  assign fsm_busy = fsm_busy_q;
  assign i2c_al   = bit_al;

endmodule
`default_nettype wire

// File: doc/i2c_master_byte_ctrl.md
# i2c_master_byte_ctrl

Byte-level sequencer of the I2C master. It sits between the register/command block and the I2C bit controller. It turns one byte command (optional START, WRITE or READ of 8 bits, ACK phase, optional STOP) into a series of single-bit commands and bit-controller handshakes. It also shifts data in and out MSB-first and reports completion, the received ACK and arbitration loss upstream.

## Interface
Parameters:
- TIMEOUT_CYCLES, 65535: watchdog limit in clk cycles; used only with I2C_BYTE_CTRL_TIMEOUT_EN.

Ports:
- clk  in  1  core clock
- rstn  in  1  synchronous, active-low reset
- ena  in  1  core enable; while low, state machine held in IDLE
- start, stop, read, write  in  1 each  command bits, held by upstream until cmd_ack
- ack_in  in  1  ACK bit the master sends after a READ (0 = ACK, 1 = NACK)
- din  in  8  byte to transmit
- cmd_ack  out  1  one-cycle completion pulse
- ack_out  out  1  ACK received from slave after a WRITE
- dout  out  8  received byte
- i2c_al  out  1  arbitration lost, equal to bit_al (combinational)
- timeout  out  1  one-cycle watchdog abort pulse
- fsm_busy  out  1  high when state ≠ IDLE, to bit controller fsm_busy_i
- bit_cmd  out  4  bit command: NOP 4'b0000, START 4'b0001, STOP 4'b0010, WRITE 4'b0100, READ 4'b1000 (codebase I2C_CMD_* values)
- bit_ack  in  1  bit-controller command acknowledge pulse
- bit_al  in  1  bit-controller arbitration lost
- bit_din  out  1  data bit to bit controller
- bit_dout  in  1  sampled SDA from bit controller

## Operation
- Internal storage: 8-bit shift register sr and 3-bit counter cnt. dout equals sr.
- go = (read | write | stop) & ~cmd_ack.
- States: IDLE, START, WRITE, READ, ACK, STOP.
- IDLE, when go is high:
  - load sr ← din and cnt ← 7.
  - Priority of the next state: start → START; else read → READ; else write → WRITE; else STOP.
  - bit_cmd takes the matching code.
- START: on bit_ack, go to READ if read is set, otherwise WRITE.
- WRITE/READ: on each bit_ack, sr ← {sr[6:0], bit_dout} and cnt decrements. On bit_ack with cnt == 0, go to ACK.
  - After a WRITE byte, the ACK phase issues bit_cmd READ.
  - After a READ byte, the ACK phase issues bit_cmd WRITE.
- bit_din: ack_in during ACK of a READ byte; sr[7] otherwise.
- ACK: on bit_ack, ack_out ← bit_dout.
  - If stop is set, go to STOP (bit_cmd STOP).
  - Otherwise go to IDLE, with bit_cmd NOP and a cmd_ack pulse.
- STOP: on bit_ack, go to IDLE with bit_cmd NOP and a cmd_ack pulse.
- Stop-only command (stop set, no read, no write): IDLE → STOP → IDLE.
- bit_al high in any state:
  - next cycle: state IDLE, bit_cmd NOP, cnt 0.
  - no cmd_ack; ack_out and sr keep their values.
- ena low: same abort as bit_al, with no flag raised.
- Reset values: state IDLE, bit_cmd NOP, sr 8'h00, cnt 0, cmd_ack 0, ack_out 0, timeout 0, fsm_busy 0.

## Timing
- All outputs except i2c_al and bit_din are registered. bit_din is combinational from sr, state and ack_in.
- bit_cmd and sr update on the clk edge after bit_ack is sampled. bit_din is therefore valid one cycle after bit_ack, which is before the bit controller's next clk_en.
- This requires bit-controller prescale clk_cnt ≥ 1.
- cmd_ack is asserted exactly one cycle, in the cycle following the final bit_ack. go is masked that cycle, so held command bits do not retrigger.
- Command latency: cmd_ack follows the final bit_ack by 1 cycle.
  - A byte with START and STOP issues 11 bit commands: START, 8 data bits, ACK bit, STOP.
- Simultaneous bit_ack and bit_al: bit_al wins; no state advance, no cmd_ack.
- Upstream must not change din, read, write or ack_in while fsm_busy is high. stop may be asserted any time before ACK completes.

## Configuration
- Macro I2C_BYTE_CTRL_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on every bit_ack and while in IDLE, and counts otherwise.
  - When it reaches TIMEOUT_CYCLES, the block aborts exactly like bit_al (IDLE, bit_cmd NOP, no cmd_ack) and pulses timeout for one cycle.
- Undefined: no counter is implemented and timeout is tied to 0.

## Test plan
- start=1, write=1, din=8'hA5, slave ACKs:
  - bit_cmd sequence is START, 8×WRITE with bit_din 1,0,1,0,0,1,0,1, then READ.
  - ack_out=0; one cmd_ack pulse.
- read=1, ack_in=1, stop=1, slave drives 8'h3C:
  - 8×READ, then WRITE with bit_din=1, then STOP.
  - dout=8'h3C; cmd_ack once, after the STOP bit_ack.
- stop=1 only: bit_cmd goes STOP then NOP; cmd_ack 1 cycle after bit_ack; fsm_busy high for exactly that span.
- Inject bit_al during bit 4 of a write with bit_ack in the same cycle:
  - next cycle state IDLE, bit_cmd NOP, i2c_al=1, no cmd_ack.
  - a subsequent write completes normally.
- With I2C_BYTE_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=100, bit_ack withheld after START:
  - timeout pulses 100 cycles after the command is issued; returns to IDLE; no cmd_ack.
- rstn low mid-READ for 1 cycle: all outputs return to their reset values on the next edge; bit_cmd NOP.
